mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 97 +++++++++
 tb/tb_mult_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one pipelined fixed-point multiplier among NREQ requesters
module mult_arbiter #(
  parameter int NUMWIDTH = 16,
  parameter int NREQ = 4,
  parameter int MULT_LAT = 1,
  parameter int SATURATE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*(NUMWIDTH+1)-1:0] req_a,
  input  logic [NREQ*(NUMWIDTH+1)-1:0] req_b,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              cfg_mask,
  output logic [NUMWIDTH:0]            mult_a,
  output logic [NUMWIDTH:0]            mult_b,
  input  logic [NUMWIDTH:0]            mult_ab,
  input  logic                         mult_clip_int,
  input  logic                         mult_clip_frac,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [NUMWIDTH:0]            rsp_ab,
  output logic                         rsp_clip_int,
  output logic                         rsp_clip_frac,
  output logic                         idle
);
  localparam int W = NUMWIDTH + 1;
  localparam int IW = $clog2(NREQ);
  localparam int DEPTH = MULT_LAT + 1;
  logic [IW-1:0] last_grant, grant_idx;
  logic [IW:0] cand;
  logic [NREQ-1:0] elig;
  logic hs;
  logic [W-1:0] a_sel, b_sel, mult_a_q, mult_b_q, rsp_ab_q, res;
  logic [NUMWIDTH-1:0] mag;
  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0][IW-1:0] tag_idx;
  logic [NREQ-1:0] rsp_valid_q;
  logic rsp_ci_q, rsp_cf_q;
  // scan from farthest to nearest so the requester right after last_grant wins
  always_comb begin
    elig = rst ? '0 : req_valid & cfg_mask;
    grant_idx = last_grant;
    hs = 1'b0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      cand = cand >= (IW+1)'(NREQ) ? cand - (IW+1)'(NREQ) : cand;
      if (elig[cand[IW-1:0]]) begin
        grant_idx = cand[IW-1:0];
        hs = 1'b1;
      end
    end
    req_ready = hs ? NREQ'(1) << grant_idx : '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = req_ready[i] ? req_a[i*W +: W] : a_sel;
      b_sel = req_ready[i] ? req_b[i*W +: W] : b_sel;
    end
    mag = (SATURATE != 0 && mult_clip_int) ? '1 : mult_ab[NUMWIDTH-1:0];
    res = mag == '0 ? '0 : {mult_ab[NUMWIDTH], mag};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NREQ-1);
      mult_a_q <= '0;
      mult_b_q <= '0;
      tag_v <= '0;
      tag_idx <= '0;
      rsp_valid_q <= '0;
      rsp_ab_q <= '0;
      rsp_ci_q <= 1'b0;
      rsp_cf_q <= 1'b0;
    end else begin
      if (hs) last_grant <= grant_idx;
      mult_a_q <= hs ? a_sel : '0;
      mult_b_q <= hs ? b_sel : '0;
      tag_v[0] <= hs;
      tag_idx[0] <= grant_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      rsp_valid_q <= tag_v[DEPTH-1] ? NREQ'(1) << tag_idx[DEPTH-1] : '0;
      rsp_ab_q <= tag_v[DEPTH-1] ? res : '0;
      rsp_ci_q <= tag_v[DEPTH-1] & mult_clip_int;
      rsp_cf_q <= tag_v[DEPTH-1] & mult_clip_frac;
    end
  end
  assign mult_a = rst ? '0 : mult_a_q;
  assign mult_b = rst ? '0 : mult_b_q;
  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_ab = rst ? '0 : rsp_ab_q;
  assign rsp_clip_int = ~rst & rsp_ci_q;
  assign rsp_clip_frac = ~rst & rsp_cf_q;
  assign idle = rst | (~|tag_v & ~hs);
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench with a behavioural multiplier and round-robin reference model
module tb_mult_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] req_valid = 0, cfg_mask = 4'hF, req_ready, rsp_valid;
  logic [67:0] req_a = 0, req_b = 0;
  logic [16:0] mult_a, mult_b, mult_ab = 0, rsp_ab;
  logic mult_clip_int = 0, mult_clip_frac = 0, rsp_clip_int, rsp_clip_frac, idle;
  int tests = 0, fails = 0, cyc = 0, ptr = 3;
  typedef struct {int due; int idx; logic [16:0] ab; logic ci; logic cf;} exp_t;
  exp_t q[$];

  mult_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cfg_mask(cfg_mask), .mult_a(mult_a), .mult_b(mult_b), .mult_ab(mult_ab),
    .mult_clip_int(mult_clip_int), .mult_clip_frac(mult_clip_frac), .rsp_valid(rsp_valid),
    .rsp_ab(rsp_ab), .rsp_clip_int(rsp_clip_int), .rsp_clip_frac(rsp_clip_frac), .idle(idle));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 8.8 sign-magnitude product: {clip_int, clip_frac, sign, magnitude}
  function automatic logic [18:0] mul_raw(input logic [16:0] a, input logic [16:0] b);
    logic [31:0] p;
    p = 32'(a[15:0]) * 32'(b[15:0]);
    return {|p[31:24], |p[7:0], a[16] ^ b[16], p[23:8]};
  endfunction

  always @(posedge clk) begin
    logic [18:0] r;
    r = mul_raw(mult_a, mult_b);
    mult_ab <= r[16:0];
    mult_clip_int <= r[18];
    mult_clip_frac <= r[17];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // one clock: check at the falling edge, then advance to just after the rising edge
  task automatic step();
    int g;
    logic [3:0] e;
    logic [18:0] r;
    logic [15:0] mag;
    bit busy;
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp", {rsp_clip_int, rsp_clip_frac, rsp_ab}, 0);
      chk("rst_mult", {mult_a, mult_b}, 0);
      chk("rst_idle", 32'(idle), 1);
      q.delete();
      ptr = 3;
    end else begin
      e = req_valid & cfg_mask;
      g = -1;
      for (int k = 4; k >= 1; k--) if (e[(ptr + k) % 4]) g = (ptr + k) % 4;
      chk("ready", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
      if (g >= 0) begin
        r = mul_raw(req_a[g*17 +: 17], req_b[g*17 +: 17]);
        mag = r[18] ? 16'hFFFF : r[15:0];
        q.push_back('{cyc + 3, g, mag == 0 ? 17'h0 : {r[16], mag}, r[18], r[17]});
        ptr = g;
      end
      busy = g >= 0;
      foreach (q[i]) if (q[i].due > cyc) busy = 1;
      chk("idle", 32'(idle), 32'(!busy));
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != 0) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
        else begin
          exp_t x;
          x = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << x.idx);
          chk("rsp_cycle", 32'(cyc), 32'(x.due));
          chk("rsp_ab", 32'(rsp_ab), 32'(x.ab));
          chk("rsp_flags", {rsp_clip_int, rsp_clip_frac}, {x.ci, x.cf});
        end
      end else begin
        chk("rsp_quiet", {rsp_clip_int, rsp_clip_frac, rsp_ab}, 0);
        if (q.size() != 0 && q[0].due <= cyc) begin
          chk("missing_rsp", 32'(rsp_valid), 32'(1) << q[0].idx);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic idle_n(input int n);
    req_valid = 0;
    repeat (n) step();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*17 +: 17] = ($urandom % 2) ? 17'($urandom) : 17'($urandom) & 17'h103FF;
      req_b[i*17 +: 17] = ($urandom % 2) ? 17'($urandom) : 17'($urandom) & 17'h103FF;
    end
  endtask

  initial begin
    repeat (2) step();
    rst = 0;
    req_a[16:0] = 17'h00180;
    req_b[16:0] = 17'h00200;
    req_valid = 4'b0001;
    step();
    idle_n(4);
    rand_ops();
    req_valid = 4'hF;
    repeat (8) step();
    idle_n(4);
    req_a[33:17] = 17'h0C800;
    req_b[33:17] = 17'h10200;
    req_valid = 4'b0010;
    step();
    idle_n(4);
    req_a[67:51] = 17'h10100;
    req_b[67:51] = 17'h00000;
    req_valid = 4'b1000;
    step();
    idle_n(4);
    cfg_mask = 4'b1011;
    req_valid = 4'b0100;
    repeat (3) step();
    cfg_mask = 4'hF;
    step();
    idle_n(4);
    rand_ops();
    req_valid = 4'hF;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    idle_n(5);
    req_valid = 4'hF;
    step();
    idle_n(4);
    for (int n = 0; n < 300; n++) begin
      rand_ops();
      req_valid = 4'($urandom);
      cfg_mask = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      step();
    end
    cfg_mask = 4'hF;
    idle_n(6);
    chk("drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
